// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t   : fetch controller states (FETCH, SQUASH, HALTED)
//   WORD_BYTES      : bytes per instruction word (PC increment)
//   PC_INIT_DEFAULT : default reset PC
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } fetch_state_t;

    localparam int          WORD_BYTES      = 4;
    localparam logic [31:0] PC_INIT_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus bundle: instruction-memory read port, redirect/halt
// controls from later stages and the IF/ID output handshake.
//   master : the fetch unit (drives imem request and the output triple)
//   slave  : memory + pipeline environment
interface fetch_unit_if #(parameter int WORD_W = 32);

    logic              imem_ren;
    logic [WORD_W-1:0] imem_addr;
    logic              imem_ihit;
    logic [WORD_W-1:0] imem_load;
    logic              redirect_i;
    logic [WORD_W-1:0] redirect_pc_i;
    logic              halt_i;
    logic              ready_i;
    logic              valid_o;
    logic [WORD_W-1:0] instr_o;
    logic [WORD_W-1:0] npc_o;
    logic [WORD_W-1:0] curr_pc_o;

    modport master (
        output imem_ren, imem_addr, valid_o, instr_o, npc_o, curr_pc_o,
        input  imem_ihit, imem_load, redirect_i, redirect_pc_i, halt_i, ready_i
    );

    modport slave (
        input  imem_ren, imem_addr, valid_o, instr_o, npc_o, curr_pc_o,
        output imem_ihit, imem_load, redirect_i, redirect_pc_i, halt_i, ready_i
    );

endinterface

// File: rtl/fetch_unit_out_buf.sv
// fetch_out_buf: one-entry output buffer of the fetch stage.
//   CLK, RST       : clock, asynchronous active-high reset
//   load           : capture load_instr/load_pc (sets valid)
//   clear          : drop the held entry (wins over load)
//   ready          : downstream accepts this cycle
//   valid/instr/npc/curr_pc : buffered triple (npc = curr_pc + 4)
//   free           : buffer can take a new word this cycle
module fetch_out_buf
    import fetch_unit_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              load,
    input  logic              clear,
    input  logic              ready,
    input  logic [WORD_W-1:0] load_instr,
    input  logic [WORD_W-1:0] load_pc,
    output logic              valid,
    output logic [WORD_W-1:0] instr,
    output logic [WORD_W-1:0] npc,
    output logic [WORD_W-1:0] curr_pc,
    output logic              free
);

    // Free when empty or when the held entry leaves this cycle.
    assign free = !valid || ready;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            valid   <= 1'b0;
            instr   <= '0;
            npc     <= '0;
            curr_pc <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (load) begin
            valid   <= 1'b1;
            instr   <= load_instr;
            curr_pc <= load_pc;
            npc     <= load_pc + WORD_W'(WORD_BYTES);   // wraps modulo 2^WORD_W
        end else if (valid && ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch stage. Owns the PC, drives the instruction
// memory read port and presents instr/npc/curr_pc to the IF/ID latch.
//   CLK, RST : clock, asynchronous active-high reset
//   fif      : fetch_unit_if.master (imem port, redirect/halt, output handshake)
//   fetch_cnt_o, stall_cnt_o : saturating perf counters, present only when
//                              FETCH_PERF_EN is defined
// Parameters: WORD_W (data/address width), PC_INIT (word-aligned reset PC).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int                WORD_W  = 32,
    parameter logic [WORD_W-1:0] PC_INIT = WORD_W'(PC_INIT_DEFAULT)
) (
    input  logic         CLK,
    input  logic         RST,
    fetch_unit_if.master fif
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]  fetch_cnt_o,
    output logic [31:0]  stall_cnt_o
`endif
);

    fetch_state_t      state;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] sq_addr;     // address of the read being drained in SQUASH
    logic              req_hold;    // request issued, awaiting ihit
    logic              ren;
    logic [WORD_W-1:0] addr;
    logic              buf_free;
    logic              accept;
    logic              buf_clear;
    logic [WORD_W-1:0] tgt;

    assign tgt = {fif.redirect_pc_i[WORD_W-1:2], 2'b00};

    // Request logic. A request, once raised, is held until ihit even if the
    // buffer fills meanwhile; SQUASH keeps presenting the stale address so
    // the memory sees a stable request until it answers.
    always_comb begin
        ren  = 1'b0;
        addr = pc;
        case (state)
            FETCH:   ren = req_hold || buf_free;
            SQUASH:  begin
                ren  = 1'b1;
                addr = sq_addr;
            end
            default: ren = 1'b0;
        endcase
        if (RST) ren = 1'b0;
    end

    assign fif.imem_ren  = ren;
    assign fif.imem_addr = addr;

    // Returned data is only kept in FETCH and when no redirect/halt arrives.
    assign accept    = (state == FETCH) && ren && fif.imem_ihit
                       && !fif.redirect_i && !fif.halt_i;
    assign buf_clear = fif.redirect_i || fif.halt_i;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= FETCH;
            pc       <= PC_INIT;
            sq_addr  <= '0;
            req_hold <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (fif.halt_i) begin
                        state    <= HALTED;
                        req_hold <= 1'b0;
                    end else if (fif.redirect_i) begin
                        pc       <= tgt;
                        req_hold <= 1'b0;
                        // Read still in flight: drain it before using the target.
                        if (ren && !fif.imem_ihit) begin
                            state   <= SQUASH;
                            sq_addr <= pc;
                        end
                    end else if (ren) begin
                        if (fif.imem_ihit) begin
                            pc       <= pc + WORD_W'(WORD_BYTES);
                            req_hold <= 1'b0;
                        end else begin
                            req_hold <= 1'b1;
                        end
                    end
                end
                SQUASH: begin
                    if (fif.halt_i) begin
                        state <= HALTED;
                    end else begin
                        if (fif.redirect_i) pc <= tgt;
                        if (fif.imem_ihit)  state <= FETCH;
                    end
                end
                HALTED: state <= HALTED;
                default: state <= FETCH;
            endcase
        end
    end

    logic              ob_valid;
    logic [WORD_W-1:0] ob_instr;
    logic [WORD_W-1:0] ob_npc;
    logic [WORD_W-1:0] ob_curr_pc;

    fetch_out_buf #(.WORD_W(WORD_W)) u_out_buf (
        .CLK        (CLK),
        .RST        (RST),
        .load       (accept),
        .clear      (buf_clear),
        .ready      (fif.ready_i),
        .load_instr (fif.imem_load),
        .load_pc    (pc),
        .valid      (ob_valid),
        .instr      (ob_instr),
        .npc        (ob_npc),
        .curr_pc    (ob_curr_pc),
        .free       (buf_free)
    );

    assign fif.valid_o   = ob_valid;
    assign fif.instr_o   = ob_instr;
    assign fif.npc_o     = ob_npc;
    assign fif.curr_pc_o = ob_curr_pc;

`ifdef FETCH_PERF_EN
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetch_cnt_o <= '0;
            stall_cnt_o <= '0;
        end else begin
            if (ob_valid && fif.ready_i && fetch_cnt_o != 32'hFFFF_FFFF)
                fetch_cnt_o <= fetch_cnt_o + 32'd1;
            if (ren && !fif.imem_ihit && stall_cnt_o != 32'hFFFF_FFFF)
                stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    logic RST2 = 1'b1;
    always #5 CLK = ~CLK;

    int errs = 0;
    int checks = 0;

    logic mem_auto = 1'b1;   // memory answers every request in the same cycle
    logic tb_ihit  = 1'b0;   // manual ihit when mem_auto is low

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1234_5678;
    endfunction

    fetch_unit_if #(.WORD_W(32)) fif ();
    fetch_unit_if #(.WORD_W(32)) fif2 ();

    assign fif.imem_ihit  = mem_auto ? fif.imem_ren : tb_ihit;
    assign fif.imem_load  = mem_word(fif.imem_addr);

    assign fif2.imem_ihit     = fif2.imem_ren;
    assign fif2.imem_load     = mem_word(fif2.imem_addr);
    assign fif2.redirect_i    = 1'b0;
    assign fif2.redirect_pc_i = 32'h0;
    assign fif2.halt_i        = 1'b0;
    assign fif2.ready_i       = 1'b1;

`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt, stall_cnt, fetch_cnt2, stall_cnt2;
`endif

    fetch_unit #(.WORD_W(32), .PC_INIT(32'h0000_0000)) dut (
        .CLK (CLK),
        .RST (RST),
        .fif (fif)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o (fetch_cnt),
        .stall_cnt_o (stall_cnt)
`endif
    );

    fetch_unit #(.WORD_W(32), .PC_INIT(32'hFFFF_FFFC)) dut_wrap (
        .CLK (CLK),
        .RST (RST2),
        .fif (fif2)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt_o (fetch_cnt2),
        .stall_cnt_o (stall_cnt2)
`endif
    );

    task automatic test_reset();
        fif.ready_i = 1'b1; fif.redirect_i = 1'b0; fif.redirect_pc_i = '0; fif.halt_i = 1'b0;
        mem_auto = 1'b1;
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        checks++; if (fif.imem_ren !== 1'b0) begin errs++; $display("FAIL reset_ren got=%b exp=0", fif.imem_ren); end
        checks++; if (fif.valid_o !== 1'b0) begin errs++; $display("FAIL reset_valid got=%b exp=0", fif.valid_o); end
        checks++; if (fif.instr_o !== 32'h0) begin errs++; $display("FAIL reset_instr got=%h exp=0", fif.instr_o); end
        checks++; if (fif.npc_o !== 32'h0) begin errs++; $display("FAIL reset_npc got=%h exp=0", fif.npc_o); end
        checks++; if (fif.curr_pc_o !== 32'h0) begin errs++; $display("FAIL reset_curr_pc got=%h exp=0", fif.curr_pc_o); end
        RST = 1'b0;
    endtask

    task automatic test_stream();
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK); @(negedge CLK);
            checks++; if (fif.valid_o !== 1'b1) begin errs++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, fif.valid_o); end
            checks++; if (fif.curr_pc_o !== 32'(4*i)) begin errs++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, fif.curr_pc_o, 32'(4*i)); end
            checks++; if (fif.npc_o !== 32'(4*i+4)) begin errs++; $display("FAIL stream_npc[%0d] got=%h exp=%h", i, fif.npc_o, 32'(4*i+4)); end
            checks++; if (fif.instr_o !== mem_word(32'(4*i))) begin errs++; $display("FAIL stream_instr[%0d] got=%h exp=%h", i, fif.instr_o, mem_word(32'(4*i))); end
        end
    endtask

    task automatic test_stall();
        logic [31:0] cp;
        cp = fif.curr_pc_o;
        fif.ready_i = 1'b0;
        #1;
        checks++; if (fif.imem_ren !== 1'b0) begin errs++; $display("FAIL stall_ren0 got=%b exp=0", fif.imem_ren); end
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK); @(negedge CLK);
            checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== cp) begin errs++; $display("FAIL stall_frozen[%0d] got=%b/%h exp=1/%h", i, fif.valid_o, fif.curr_pc_o, cp); end
            checks++; if (fif.imem_ren !== 1'b0) begin errs++; $display("FAIL stall_ren[%0d] got=%b exp=0", i, fif.imem_ren); end
            checks++; if (fif.imem_addr !== cp + 32'd4) begin errs++; $display("FAIL stall_pc[%0d] got=%h exp=%h", i, fif.imem_addr, cp + 32'd4); end
        end
        fif.ready_i = 1'b1;
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== cp + 32'd4) begin errs++; $display("FAIL stall_resume got=%b/%h exp=1/%h", fif.valid_o, fif.curr_pc_o, cp + 32'd4); end
    endtask

    task automatic test_squash();
        logic [31:0] a;
        @(negedge CLK); mem_auto = 1'b0; tb_ihit = 1'b0; #1;
        a = fif.imem_addr;
        checks++; if (fif.imem_ren !== 1'b1) begin errs++; $display("FAIL squash_req got=%b exp=1", fif.imem_ren); end
        @(posedge CLK); @(negedge CLK);
        fif.redirect_i = 1'b1; fif.redirect_pc_i = 32'h100; #1;
        checks++; if (fif.imem_ren !== 1'b1 || fif.imem_addr !== a) begin errs++; $display("FAIL squash_hold1 got=%b/%h exp=1/%h", fif.imem_ren, fif.imem_addr, a); end
        @(posedge CLK); @(negedge CLK);
        fif.redirect_i = 1'b0; #1;
        checks++; if (fif.valid_o !== 1'b0) begin errs++; $display("FAIL squash_valid got=%b exp=0", fif.valid_o); end
        checks++; if (fif.imem_ren !== 1'b1 || fif.imem_addr !== a) begin errs++; $display("FAIL squash_hold2 got=%b/%h exp=1/%h", fif.imem_ren, fif.imem_addr, a); end
        @(posedge CLK); @(negedge CLK);
        tb_ihit = 1'b1; #1;
        checks++; if (fif.imem_addr !== a) begin errs++; $display("FAIL squash_hold3 got=%h exp=%h", fif.imem_addr, a); end
        @(posedge CLK); @(negedge CLK);
        tb_ihit = 1'b0; mem_auto = 1'b1; #1;
        checks++; if (fif.valid_o !== 1'b0) begin errs++; $display("FAIL squash_discard got=%b exp=0", fif.valid_o); end
        checks++; if (fif.imem_ren !== 1'b1 || fif.imem_addr !== 32'h100) begin errs++; $display("FAIL squash_newreq got=%b/%h exp=1/00000100", fif.imem_ren, fif.imem_addr); end
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== 32'h100 || fif.instr_o !== mem_word(32'h100)) begin errs++; $display("FAIL squash_target got=%b/%h/%h exp=1/00000100/%h", fif.valid_o, fif.curr_pc_o, fif.instr_o, mem_word(32'h100)); end
    endtask

    task automatic test_redirect_hit();
        fif.redirect_i = 1'b1; fif.redirect_pc_i = 32'h40;
        @(posedge CLK); @(negedge CLK);
        fif.redirect_i = 1'b0; #1;
        checks++; if (fif.valid_o !== 1'b0) begin errs++; $display("FAIL redir_hit_valid got=%b exp=0", fif.valid_o); end
        checks++; if (fif.imem_addr !== 32'h40) begin errs++; $display("FAIL redir_hit_addr got=%h exp=00000040", fif.imem_addr); end
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== 32'h40 || fif.npc_o !== 32'h44) begin errs++; $display("FAIL redir_hit_target got=%b/%h/%h exp=1/00000040/00000044", fif.valid_o, fif.curr_pc_o, fif.npc_o); end
    endtask

    task automatic test_wrap();
        RST2 = 1'b1;
        @(negedge CLK);
        RST2 = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif2.valid_o !== 1'b1 || fif2.curr_pc_o !== 32'hFFFF_FFFC || fif2.npc_o !== 32'h0) begin errs++; $display("FAIL wrap_first got=%b/%h/%h exp=1/fffffffc/00000000", fif2.valid_o, fif2.curr_pc_o, fif2.npc_o); end
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif2.curr_pc_o !== 32'h0 || fif2.npc_o !== 32'h4) begin errs++; $display("FAIL wrap_second got=%h/%h exp=00000000/00000004", fif2.curr_pc_o, fif2.npc_o); end
    endtask

    task automatic test_halt_reset();
        logic [31:0] a;
        @(negedge CLK);
        mem_auto = 1'b1;
        fif.halt_i = 1'b1; fif.redirect_i = 1'b1; fif.redirect_pc_i = 32'h200; #1;
        a = fif.imem_addr;
        @(posedge CLK); @(negedge CLK);
        fif.halt_i = 1'b0; fif.redirect_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++; if (fif.imem_ren !== 1'b0 || fif.valid_o !== 1'b0) begin errs++; $display("FAIL halt_idle[%0d] got=%b/%b exp=0/0", i, fif.imem_ren, fif.valid_o); end
            checks++; if (fif.imem_addr !== a) begin errs++; $display("FAIL halt_pc[%0d] got=%h exp=%h", i, fif.imem_addr, a); end
            @(posedge CLK); @(negedge CLK);
        end
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0; mem_auto = 1'b0; tb_ihit = 1'b0;
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif.imem_ren !== 1'b1 || fif.imem_addr !== 32'h0) begin errs++; $display("FAIL rst_read_req got=%b/%h exp=1/00000000", fif.imem_ren, fif.imem_addr); end
        RST = 1'b1; #1;
        checks++; if (fif.imem_ren !== 1'b0 || fif.valid_o !== 1'b0) begin errs++; $display("FAIL rst_midread got=%b/%b exp=0/0", fif.imem_ren, fif.valid_o); end
`ifdef FETCH_PERF_EN
        checks++; if (fetch_cnt !== 32'h0 || stall_cnt !== 32'h0) begin errs++; $display("FAIL rst_counters got=%h/%h exp=0/0", fetch_cnt, stall_cnt); end
`endif
        @(negedge CLK);
        RST = 1'b0; mem_auto = 1'b1;
        @(posedge CLK); @(negedge CLK);
        checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== 32'h0) begin errs++; $display("FAIL rst_restart got=%b/%h exp=1/00000000", fif.valid_o, fif.curr_pc_o); end
    endtask

    // Reference: the accepted stream is a sequence of PCs that step by 4 and
    // jump to (target & ~3) after each redirect; memory is a random-latency
    // responder that requires a stable address until it answers.
    task automatic test_random();
        logic [31:0] exp_pc, req_addr, prev_pc, prev_instr;
        logic        busy, was_busy, prev_valid, prev_ready, prev_redir;
        int          lat, ntx;
        RST = 1'b1; fif.ready_i = 1'b1; fif.redirect_i = 1'b0; fif.halt_i = 1'b0;
        mem_auto = 1'b0; tb_ihit = 1'b0;
        @(negedge CLK);
        RST = 1'b0;
        exp_pc = 32'h0; busy = 1'b0; lat = 0; ntx = 0; req_addr = '0;
        prev_valid = 1'b0; prev_ready = 1'b1; prev_redir = 1'b0; prev_pc = '0; prev_instr = '0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge CLK);
            if (prev_redir) begin
                checks++; if (fif.valid_o !== 1'b0) begin errs++; $display("FAIL rnd_redir_clear cyc=%0d got=%b exp=0", cyc, fif.valid_o); end
            end else if (prev_valid && !prev_ready) begin
                checks++; if (fif.valid_o !== 1'b1 || fif.curr_pc_o !== prev_pc || fif.instr_o !== prev_instr) begin errs++; $display("FAIL rnd_frozen cyc=%0d got=%b/%h exp=1/%h", cyc, fif.valid_o, fif.curr_pc_o, prev_pc); end
            end
            fif.ready_i       = ($urandom_range(0, 9) < 7);
            fif.redirect_i    = ($urandom_range(0, 11) == 0);
            fif.redirect_pc_i = $urandom() & 32'h0000_FFFF;
            #1;
            was_busy = busy;
            if (fif.imem_ren) begin
                if (!busy) begin
                    busy = 1'b1; req_addr = fif.imem_addr; lat = $urandom_range(0, 3);
                end else begin
                    checks++; if (fif.imem_addr !== req_addr) begin errs++; $display("FAIL rnd_addr_stable cyc=%0d got=%h exp=%h", cyc, fif.imem_addr, req_addr); end
                end
                tb_ihit = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                checks++; if (busy) begin errs++; $display("FAIL rnd_dropped_req cyc=%0d got=0 exp=1", cyc); end
                tb_ihit = 1'b0;
            end
            if (!fif.valid_o || fif.ready_i) begin
                checks++; if (fif.imem_ren !== 1'b1) begin errs++; $display("FAIL rnd_ren_free cyc=%0d got=%b exp=1", cyc, fif.imem_ren); end
            end else if (!was_busy) begin
                checks++; if (fif.imem_ren !== 1'b0) begin errs++; $display("FAIL rnd_ren_full cyc=%0d got=%b exp=0", cyc, fif.imem_ren); end
            end
            if (fif.valid_o && fif.ready_i && !fif.redirect_i) begin
                checks++;
                if (fif.curr_pc_o !== exp_pc || fif.npc_o !== exp_pc + 32'd4 || fif.instr_o !== mem_word(exp_pc)) begin
                    errs++; $display("FAIL rnd_xfer cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, fif.curr_pc_o, fif.npc_o, fif.instr_o, exp_pc, exp_pc + 32'd4, mem_word(exp_pc));
                end
                exp_pc = exp_pc + 32'd4;
                ntx++;
            end
            if (fif.redirect_i) exp_pc = fif.redirect_pc_i & 32'hFFFF_FFFC;
            if (tb_ihit) busy = 1'b0;
            prev_valid = fif.valid_o; prev_ready = fif.ready_i; prev_redir = fif.redirect_i;
            prev_pc = fif.curr_pc_o; prev_instr = fif.instr_o;
        end
        @(negedge CLK);
        fif.redirect_i = 1'b0; tb_ihit = 1'b0;
        checks++; if (ntx < 40) begin errs++; $display("FAIL rnd_progress got=%0d exp>=40", ntx); end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_squash();
        test_redirect_hit();
        test_wrap();
        test_halt_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
